pipelined_adder_param: RTL and testbench
========================================

Name: pipelined_adder_param

Overview:
- Parametrised, valid/ready pipelined adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal carry-chained chunks, one chunk per pipeline stage.
- Adds operand skew and result deskew registers so a new operation can be accepted every cycle.
- Adds backpressure, subtract mode and signed-overflow reporting; sits in datapaths as a drop-in registered arithmetic unit.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages and carry chunks, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented on a/b/cin/sub.
- in_ready  output  1  block accepts the operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=1 at clk edge), synchronous, including mid-operation:
  - all stage valid bits cleared;
  - sum=0, cout=0, ovf=0, out_valid=0;
  - in-flight operations are discarded;
  - rst has priority over every other input.
- Stall and handshake:
  - Internal operands: B' = sub ? ~b : b; C0 = sub ? ~cin : cin.
  - Global advance signal: adv = !out_valid | out_ready.
  - in_ready = adv (combinational; 1 immediately after reset).
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - When adv=0, every pipeline register (data, carry, valid) holds.
  - A bubble enters stage 1 when adv=1 and in_valid=0; bubbles are not compressed.
- Stage k (k=0..STAGES-1), on adv:
  - computes {c[k+1], r[k]} = A[k] + B'[k] + c[k], where A[k] and B'[k] are chunk k of width CW, and c[0] = C0;
  - registers r[k] and c[k+1];
  - A[k] and B'[k] reach stage k through k skew registers;
  - r[k] reaches the output through STAGES-1-k deskew registers.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stalls.
- Throughput: 1 operation/cycle while out_ready=1.
- Flags, computed in the last stage:
  - cout = carry out of bit WIDTH-1;
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- STAGES=1: degenerates to a single registered adder with the same handshake.
- Outputs are registered and held stable while out_valid=1 and out_ready=0.
- The arithmetic uses no multi-cycle paths; each stage's carry chain is CW bits long.

Decomposition:
- Package pipelined_adder_pkg holds:
  - function chunk_w(WIDTH, STAGES);
  - elaboration check that WIDTH % STAGES == 0 and STAGES >= 1;
  - localparam op encodings OP_ADD=0, OP_SUB=1.
- Sub-module adder_chunk_stage: one CW-bit slice. Inputs are a chunk, b chunk, carry in and adv. It produces a registered sum chunk and registered carry out, plus the MSB carry-in tap used for ovf in the top slice.
- Top level generates STAGES slices plus the skew/deskew shift registers and the valid pipeline.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=0x0F, b=0x01, cin=0, sub=0 -> after 2 cycles sum=0x10, cout=0, ovf=0; proves the inter-stage carry.
- WIDTH=8, STAGES=2: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
- Sub mode, WIDTH=8: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, ovf=1.
- WIDTH=32, STAGES=4: 8 back-to-back operations with random operands -> 8 results in consecutive cycles, in order, starting at cycle 4; all match the reference model.
- Backpressure: hold out_ready=0 for 3 cycles with the pipeline full -> in_ready=0, sum/out_valid stable, nothing lost or duplicated; release -> remaining results drain in order.
- Assert rst for 1 cycle with 3 operations in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0, in_ready=1; no stale result ever appears.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the chunked, carry-pipelined adder/subtractor.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal only when the width splits into equal, non-empty chunks.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_param_chunk.sv
// One CW-bit slice of the carry chain: registered sum chunk, carry out and
// the carry into the slice MSB (only the top slice's tap feeds overflow).
module adder_chunk_stage #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] r_o,
    output logic          c_o,
    output logic          cmsb_o
);

    logic [CW:0]   sum_w;
    logic [CW-1:0] r_q;
    logic          c_q;
    logic          cmsb_q;

    assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            c_q    <= 1'b0;
            cmsb_q <= 1'b0;
        end else if (adv) begin
            r_q    <= sum_w[CW-1:0];
            c_q    <= sum_w[CW];
            cmsb_q <= a_i[CW-1] ^ b_i[CW-1] ^ sum_w[CW-1];
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign cmsb_o = cmsb_q;

endmodule

// File: rtl/pipelined_adder_param.sv
// Valid/ready pipelined adder/subtractor: one CW-bit carry chunk per stage,
// operands skewed in and result chunks deskewed out so it accepts one op per cycle.
module pipelined_adder_param
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder_param: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES:0]   carry;
    logic [STAGES-1:0] cmsb;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction as A + ~B + ~borrow, so cout=1 means no borrow.
    assign b_eff    = (sub == OP_SUB) ? ~b : b;
    assign carry[0] = (sub == OP_SUB) ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DSK = STAGES - 1 - k;

        logic [CW-1:0] a_stg;
        logic [CW-1:0] b_stg;
        logic [CW-1:0] r_stg;

        if (k == 0) begin : g_direct
            assign a_stg = a[CW-1:0];
            assign b_stg = b_eff[CW-1:0];
        end else begin : g_skew
            logic [CW-1:0] a_skew_q [k];
            logic [CW-1:0] b_skew_q [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_skew_q[j] <= '0;
                        b_skew_q[j] <= '0;
                    end
                end else if (adv) begin
                    a_skew_q[0] <= a[k*CW +: CW];
                    b_skew_q[0] <= b_eff[k*CW +: CW];
                    for (int j = 1; j < k; j++) begin
                        a_skew_q[j] <= a_skew_q[j-1];
                        b_skew_q[j] <= b_skew_q[j-1];
                    end
                end
            end

            assign a_stg = a_skew_q[k-1];
            assign b_stg = b_skew_q[k-1];
        end

        adder_chunk_stage #(
            .CW(CW)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .adv    (adv),
            .a_i    (a_stg),
            .b_i    (b_stg),
            .c_i    (carry[k]),
            .r_o    (r_stg),
            .c_o    (carry[k+1]),
            .cmsb_o (cmsb[k])
        );

        if (DSK == 0) begin : g_out_direct
            assign sum[k*CW +: CW] = r_stg;
        end else begin : g_deskew
            logic [CW-1:0] dsk_q [DSK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DSK; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else if (adv) begin
                    dsk_q[0] <= r_stg;
                    for (int j = 1; j < DSK; j++) begin
                        dsk_q[j] <= dsk_q[j-1];
                    end
                end
            end

            assign sum[k*CW +: CW] = dsk_q[DSK-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign cout      = carry[STAGES];
    assign ovf       = carry[STAGES] ^ cmsb[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_param.sv
// Directed bench: an 8-bit/2-stage and a 32-bit/4-stage instance sharing one clock.
module tb_pipelined_adder_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v8, rdy8, ov8, ordy8, ci8, sb8, co8, of8;
    logic [7:0] a8, b8, s8;

    logic        v32, rdy32, ov32, ordy32, ci32, sb32, co32, of32;
    logic [31:0] a32, b32, s32;

    int n_pass  = 0;
    int n_total = 0;

    pipelined_adder_param #(.WIDTH(8), .STAGES(2)) u_add8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
        .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(ordy8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    pipelined_adder_param #(.WIDTH(32), .STAGES(4)) u_add32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
        .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(ordy32), .sum(s32),
        .cout(co32), .ovf(of32)
    );

    // 8-bit vectors: a, b, cin, sub -> sum, cout, ovf (hand-computed)
    logic [7:0] ta8 [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10};
    logic [7:0] tb8 [6] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01, 8'h05};
    logic       tc8 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ts8 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] es8 [6] = '{8'h10, 8'h01, 8'h80, 8'hFE, 8'h7F, 8'h0A};
    logic       ec8 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       eo8 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // 32-bit vectors
    logic [31:0] va [8] = '{32'h0000_00FF, 32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'h1234_5678, 32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] vb [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                            32'h1111_1111, 32'h0000_0001, 32'h0000_0001, 32'h0000_BEEF};
    logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] es [8] = '{32'h0000_0100, 32'h0100_0000, 32'h0000_0000, 32'h8000_0000,
                            32'h2345_6789, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hDEAC_FFFF};
    logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_reset();
        rst = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0; ordy8 = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0; ordy32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({ov8, s8, co8, of8} !== 11'd0) $display("FAIL reset8 outputs: got %b want 0", {ov8, s8, co8, of8}); else n_pass++;
        n_total++; if ({ov32, s32, co32, of32} !== 35'd0) $display("FAIL reset32 outputs: got %h want 0", {ov32, s32, co32, of32}); else n_pass++;
        ordy8 = 1'b0; ordy32 = 1'b0;
        #1;
        n_total++; if (rdy8 !== 1'b1) $display("FAIL reset8 in_ready: got %b want 1", rdy8); else n_pass++;
        n_total++; if (rdy32 !== 1'b1) $display("FAIL reset32 in_ready: got %b want 1", rdy32); else n_pass++;
        ordy8 = 1'b1; ordy32 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one op to the 8-bit DUT and wait (bounded) for its result.
    task automatic run8(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                        input logic s_v, output logic [7:0] s_o, output logic c_o,
                        output logic o_o, output int lat);
        a8 = a_v; b8 = b_v; ci8 = c_v; sb8 = s_v; v8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s_o = s8; c_o = co8; o_o = of8;
    endtask

    task automatic test_arith8(input int lo, input int hi, input string tag);
        logic [7:0] s;
        logic c, o;
        int lat;
        for (int i = lo; i <= hi; i++) begin
            run8(ta8[i], tb8[i], tc8[i], ts8[i], s, c, o, lat);
            n_total++; if (lat !== 2) $display("FAIL %s[%0d] latency: got %0d want 2", tag, i, lat); else n_pass++;
            n_total++; if (s !== es8[i]) $display("FAIL %s[%0d] sum: got %h want %h", tag, i, s, es8[i]); else n_pass++;
            n_total++; if (c !== ec8[i]) $display("FAIL %s[%0d] cout: got %b want %b", tag, i, c, ec8[i]); else n_pass++;
            n_total++; if (o !== eo8[i]) $display("FAIL %s[%0d] ovf: got %b want %b", tag, i, o, eo8[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gs [$];
        logic        gc [$];
        logic        go [$];
        int          gcyc [$];
        ordy32 = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a32 = va[i]; b32 = vb[i]; ci32 = vc[i]; sb32 = vs[i]; v32 = 1'b1;
                    @(posedge clk);
                    #1;
                end
                v32 = 1'b0;
            end
            begin
                for (int cyc = 1; cyc <= 20; cyc++) begin
                    @(posedge clk);
                    #1;
                    if (ov32) begin
                        gs.push_back(s32); gc.push_back(co32); go.push_back(of32); gcyc.push_back(cyc);
                    end
                end
            end
        join
        n_total++; if (gs.size() !== 8) $display("FAIL b2b count: got %0d want 8", gs.size()); else n_pass++;
        for (int i = 0; i < 8 && i < gs.size(); i++) begin
            n_total++; if (gcyc[i] !== 4 + i) $display("FAIL b2b[%0d] cycle: got %0d want %0d", i, gcyc[i], 4 + i); else n_pass++;
            n_total++; if (gs[i] !== es[i]) $display("FAIL b2b[%0d] sum: got %h want %h", i, gs[i], es[i]); else n_pass++;
            n_total++; if (gc[i] !== ec[i]) $display("FAIL b2b[%0d] cout: got %b want %b", i, gc[i], ec[i]); else n_pass++;
            n_total++; if (go[i] !== eo[i]) $display("FAIL b2b[%0d] ovf: got %b want %b", i, go[i], eo[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] gs [$];
        logic        gc [$];
        logic        go [$];
        logic [31:0] held;
        int  idx = 0;
        logic acc;
        for (int cyc = 0; cyc < 40 && !(idx == 8 && gs.size() == 8); cyc++) begin
            ordy32 = !(cyc >= 4 && cyc <= 6);
            if (idx < 8) begin
                a32 = va[idx]; b32 = vb[idx]; ci32 = vc[idx]; sb32 = vs[idx]; v32 = 1'b1;
            end else begin
                v32 = 1'b0;
            end
            #1;
            acc = v32 && rdy32;
            if (ov32 && ordy32) begin
                gs.push_back(s32); gc.push_back(co32); go.push_back(of32);
            end
            if (cyc >= 4 && cyc <= 6) begin
                if (cyc == 4) held = s32;
                n_total++; if (ov32 !== 1'b1) $display("FAIL stall[%0d] out_valid: got %b want 1", cyc, ov32); else n_pass++;
                n_total++; if (rdy32 !== 1'b0) $display("FAIL stall[%0d] in_ready: got %b want 0", cyc, rdy32); else n_pass++;
                if (cyc > 4) begin
                    n_total++; if (s32 !== held) $display("FAIL stall[%0d] sum held: got %h want %h", cyc, s32, held); else n_pass++;
                end
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        v32 = 1'b0;
        ordy32 = 1'b1;
        n_total++; if (gs.size() !== 8) $display("FAIL bp count: got %0d want 8", gs.size()); else n_pass++;
        n_total++; if (held !== es[0]) $display("FAIL bp held sum: got %h want %h", held, es[0]); else n_pass++;
        for (int i = 0; i < 8 && i < gs.size(); i++) begin
            n_total++; if (gs[i] !== es[i]) $display("FAIL bp[%0d] sum: got %h want %h", i, gs[i], es[i]); else n_pass++;
            n_total++; if ({gc[i], go[i]} !== {ec[i], eo[i]}) $display("FAIL bp[%0d] cout/ovf: got %b%b want %b%b", i, gc[i], go[i], ec[i], eo[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_in_flight();
        int flight [3] = '{4, 6, 7};
        int stale = 0;
        int lat;
        ordy32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a32 = va[flight[i]]; b32 = vb[flight[i]]; ci32 = vc[flight[i]]; sb32 = vs[flight[i]]; v32 = 1'b1;
            @(posedge clk);
            #1;
        end
        // reset must win over a simultaneous valid input
        rst = 1'b1;
        a32 = va[0]; b32 = vb[0]; ci32 = vc[0]; sb32 = vs[0]; v32 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v32 = 1'b0;
        n_total++; if (ov32 !== 1'b0) $display("FAIL rstflight out_valid: got %b want 0", ov32); else n_pass++;
        n_total++; if (s32 !== 32'h0) $display("FAIL rstflight sum: got %h want 0", s32); else n_pass++;
        n_total++; if ({co32, of32} !== 2'b00) $display("FAIL rstflight cout/ovf: got %b want 00", {co32, of32}); else n_pass++;
        n_total++; if (rdy32 !== 1'b1) $display("FAIL rstflight in_ready: got %b want 1", rdy32); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (ov32) stale++;
        end
        n_total++; if (stale !== 0) $display("FAIL rstflight stale results: got %0d want 0", stale); else n_pass++;
        a32 = va[3]; b32 = vb[3]; ci32 = vc[3]; sb32 = vs[3]; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_total++; if (lat !== 4) $display("FAIL postrst latency: got %0d want 4", lat); else n_pass++;
        n_total++; if ({s32, co32, of32} !== {es[3], ec[3], eo[3]}) $display("FAIL postrst result: got %h %b %b want %h %b %b", s32, co32, of32, es[3], ec[3], eo[3]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arith8(0, 2, "add8");
        test_arith8(3, 5, "sub8");
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
